// File: rtl/acc_requant_pool_if.sv
// Handshake bundle for acc_requant_pool: accumulator sums in, feature results out.
interface acc_requant_pool_if #(
    parameter int SUM_BIT_WIDTH = 24,
    parameter int OUT_BIT_WIDTH = 16
);
    logic                     sum_valid;
    logic [SUM_BIT_WIDTH-1:0] sum_in;
    logic                     sum_ready;
    logic                     out_valid;
    logic [OUT_BIT_WIDTH-1:0] out_data;
    logic                     out_ready;

    modport master (
        output sum_valid, sum_in, out_ready,
        input  sum_ready, out_valid, out_data
    );

    modport slave (
        input  sum_valid, sum_in, out_ready,
        output sum_ready, out_valid, out_data
    );
endinterface

// File: rtl/acc_requant_pool.sv
// Post-accumulation stage: bias add, round/shift, saturate, ReLU, optional max-pool.
// Three advance-gated registers; a stalled output freezes the whole pipe.
module acc_requant_pool #(
    parameter int SUM_BIT_WIDTH   = 24,
    parameter int BIAS_BIT_WIDTH  = 16,
    parameter int OUT_BIT_WIDTH   = 16,
    parameter int SHIFT_BIT_WIDTH = 5,
    parameter int POOL_CNT_WIDTH  = 3
) (
    input  logic                              clk,
    input  logic                              layer_reset,
    acc_requant_pool_if.slave                 io,
    input  logic signed [BIAS_BIT_WIDTH-1:0]  cfg_bias,
    input  logic        [SHIFT_BIT_WIDTH-1:0] cfg_shift,
    input  logic                              cfg_relu_en,
    input  logic        [POOL_CNT_WIDTH-1:0]  cfg_pool_len
);
    localparam int BW = SUM_BIT_WIDTH + 1;
    localparam int RW = SUM_BIT_WIDTH + 2;
    localparam int XW = BW - BIAS_BIT_WIDTH;
    localparam logic [SHIFT_BIT_WIDTH-1:0] SHIFT_MAX =
        SHIFT_BIT_WIDTH'(SUM_BIT_WIDTH - 1);
    localparam logic [POOL_CNT_WIDTH-1:0] CNT_ONE =
        POOL_CNT_WIDTH'(1);

    logic                            advance;
    logic                            s1_valid;
    logic        [BW-1:0]            s1_b;
    logic                            s2_valid;
    logic signed [OUT_BIT_WIDTH-1:0] s2_q;
    logic                            out_valid_r;
    logic signed [OUT_BIT_WIDTH-1:0] out_data_r;
    logic signed [OUT_BIT_WIDTH-1:0] pool_max;
    logic        [POOL_CNT_WIDTH-1:0] pool_cnt;

    logic        [BW-1:0]             b_next;
    logic        [SHIFT_BIT_WIDTH-1:0] shift_amt;
    logic signed [RW-1:0]             round_bias;
    logic signed [RW-1:0]             rounded;
    logic signed [RW-1:0]             shifted;
    logic                             pos_ovf;
    logic                             neg_ovf;
    logic signed [OUT_BIT_WIDTH-1:0]  sat_q;

    logic                             sel_bypass;
    logic                             sel_first;
    logic                             sel_last;
    logic signed [OUT_BIT_WIDTH-1:0]  pool_peak;

    assign advance      = !out_valid_r || io.out_ready;
    assign io.sum_ready = advance;
    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;

    // One extra bit makes sum+bias exact for any operand values.
    assign b_next = {io.sum_in[SUM_BIT_WIDTH-1], io.sum_in}
                  + {{XW{cfg_bias[BIAS_BIT_WIDTH-1]}}, cfg_bias};

    assign shift_amt = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;

    always_comb begin
        round_bias = '0;
        if (shift_amt != '0) begin
            round_bias = RW'(1) << (shift_amt - SHIFT_BIT_WIDTH'(1));
        end
        rounded = $signed({s1_b[BW-1], s1_b}) + round_bias;
        shifted = rounded >>> shift_amt;
        pos_ovf = !shifted[RW-1] && (|shifted[RW-2:OUT_BIT_WIDTH-1]);
        neg_ovf = shifted[RW-1] && !(&shifted[RW-2:OUT_BIT_WIDTH-1]);
        unique case (1'b1)
            pos_ovf: sat_q = {1'b0, {(OUT_BIT_WIDTH-1){1'b1}}};
            neg_ovf: sat_q = {1'b1, {(OUT_BIT_WIDTH-1){1'b0}}};
            default: sat_q = shifted[OUT_BIT_WIDTH-1:0];
        endcase
        if (cfg_relu_en && sat_q[OUT_BIT_WIDTH-1]) begin
            sat_q = '0;
        end
    end

    assign sel_bypass = cfg_pool_len <= CNT_ONE;
    assign sel_first  = !sel_bypass && (pool_cnt == '0);
    assign sel_last   = !sel_bypass && (pool_cnt != '0)
                     && (pool_cnt == cfg_pool_len - CNT_ONE);
    assign pool_peak  = (s2_q > pool_max) ? s2_q : pool_max;

    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            s1_valid    <= 1'b0;
            s1_b        <= '0;
            s2_valid    <= 1'b0;
            s2_q        <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            pool_max    <= '0;
            pool_cnt    <= '0;
        end else if (advance) begin
            s1_valid    <= io.sum_valid;
            s1_b        <= b_next;
            s2_valid    <= s1_valid;
            s2_q        <= sat_q;
            out_valid_r <= 1'b0;
            if (s2_valid) begin
                unique case (1'b1)
                    sel_bypass: begin
                        out_data_r  <= s2_q;
                        out_valid_r <= 1'b1;
                    end
                    sel_first: begin
                        pool_max <= s2_q;
                        pool_cnt <= CNT_ONE;
                    end
                    sel_last: begin
                        out_data_r  <= pool_peak;
                        out_valid_r <= 1'b1;
                        pool_cnt    <= '0;
                    end
                    default: begin
                        pool_max <= pool_peak;
                        pool_cnt <= pool_cnt + CNT_ONE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_acc_requant_pool.sv
// Bench for acc_requant_pool: arithmetic reference model plus directed vectors.
module tb_acc_requant_pool;
    logic clk = 1'b0;
    logic layer_reset;
    logic signed [15:0] cfg_bias;
    logic [4:0] cfg_shift;
    logic cfg_relu_en;
    logic [2:0] cfg_pool_len;

    always #5 clk = ~clk;

    acc_requant_pool_if #(.SUM_BIT_WIDTH(24), .OUT_BIT_WIDTH(16)) bus ();

    acc_requant_pool dut (
        .clk(clk),
        .layer_reset(layer_reset),
        .io(bus),
        .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift),
        .cfg_relu_en(cfg_relu_en),
        .cfg_pool_len(cfg_pool_len)
    );

    typedef struct {
        int data;
        int cyc;
        bit lat;
    } exp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    exp_t expq[$];
    int win[$];
    int got[$];
    bit prev_stall = 0;
    logic [15:0] prev_data;
    int mq, mm;
    exp_t me;

    function automatic int model_q(longint s, longint bias, int sh, bit relu);
        longint r;
        int k;
        k = (sh > 23) ? 23 : sh;
        r = s + bias;
        if (k > 0) r = r + (longint'(1) << (k - 1));
        r = r >>> k;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return int'(r);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d @cyc %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (layer_reset) begin
            prev_stall = 0;
        end else begin
            chk("sum_ready", bus.sum_ready, !bus.out_valid || bus.out_ready);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(int'($signed(bus.out_data)));
                if (expq.size() == 0) begin
                    chk("pending_result", expq.size() > 0, 1);
                end else begin
                    me = expq.pop_front();
                    chk("out_data", longint'($signed(bus.out_data)), me.data);
                    if (me.lat) chk("latency", cyc, me.cyc + 3);
                end
            end
            if (bus.sum_valid && bus.sum_ready) begin
                mq = model_q(longint'($signed(bus.sum_in)), longint'(cfg_bias),
                             int'(cfg_shift), cfg_relu_en);
                if (cfg_pool_len <= 1) begin
                    expq.push_back('{mq, cyc, rdy_mode == 0});
                end else begin
                    win.push_back(mq);
                    if (win.size() == int'(cfg_pool_len)) begin
                        mm = win[0];
                        foreach (win[i]) if (win[i] > mm) mm = win[i];
                        expq.push_back('{mm, cyc, rdy_mode == 0});
                        win.delete();
                    end
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input int s);
        int n = 0;
        bus.sum_valid = 1'b1;
        bus.sum_in = 24'(s);
        @(negedge clk);
        while (!bus.sum_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_ready_wait", n < 50, 1);
        @(posedge clk);
        #1;
        bus.sum_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int b, input int sh, input bit relu, input int pl);
        cfg_bias = 16'(b);
        cfg_shift = 5'(sh);
        cfg_relu_en = relu;
        cfg_pool_len = 3'(pl);
    endtask

    task automatic lit(input string name, input int exp);
        if (got.size() == 0) chk({name, "_present"}, got.size(), 1);
        else chk(name, got.pop_front(), exp);
    endtask

    task automatic lit_none(input string name);
        chk(name, got.size(), 0);
    endtask

    task automatic reset_pulse();
        #2;
        layer_reset = 1'b1;
        expq.delete();
        win.delete();
        got.delete();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        layer_reset = 1'b0;
    endtask

    initial begin
        layer_reset = 1'b1;
        set_cfg(0, 0, 0, 1);
        bus.sum_valid = 1'b0;
        bus.sum_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_sum_ready", bus.sum_ready, 1);
        layer_reset = 1'b0;
        drain(1);

        set_cfg(0, 4, 0, 1);
        send(24); send(8); send(7); send(-8); send(-9); send(-24);
        drain(6);
        lit("t1_round", 2);
        lit("round_half", 1);
        lit("round_below", 0);
        lit("neg_half", 0);
        lit("neg_past_half", -1);
        lit("t2_neg_round", -1);
        lit_none("t1_extra");

        set_cfg(0, 0, 0, 1);
        send(32'h7FFFFF); send(32'h800000); send(-32768);
        drain(6);
        lit("t3_pos_sat", 32767);
        lit("t3_neg_sat", -32768);
        lit("t3_min_exact", -32768);
        set_cfg(0, 0, 1, 1);
        send(32'h800000); send(5);
        drain(6);
        lit("t3_relu_neg", 0);
        lit("t3_relu_pos", 5);
        set_cfg(-150, 0, 0, 1);
        send(100);
        drain(6);
        lit("t3_bias_neg", -50);
        set_cfg(1, 0, 0, 1);
        send(32767); send(32766);
        drain(6);
        lit("t3_bias_sat", 32767);
        lit("t3_bias_edge", 32767);
        set_cfg(32767, 8, 0, 1);
        send(32'h7FFFFF);
        drain(6);
        lit("t3_wide_pos", 32767);
        set_cfg(-32768, 8, 0, 1);
        send(32'h800000);
        drain(6);
        lit("t3_wide_neg", -32768);
        set_cfg(0, 31, 0, 1);
        send(32'h7FFFFF); send(32'h800000);
        drain(6);
        lit("shift_clamp_pos", 1);
        lit("shift_clamp_neg", -1);
        lit_none("t3_extra");

        set_cfg(0, 0, 0, 4);
        send(5); send(-3); send(9); send(2);
        send(1); send(1); send(1); send(7);
        drain(8);
        lit("t4_win0", 9);
        lit("t4_win1", 7);
        lit_none("t4_exact_two");
        set_cfg(0, 0, 0, 3);
        send(-5); send(-3); send(-9);
        drain(8);
        lit("pool_signed_max", -3);
        lit_none("pool3_extra");

        set_cfg(3, 2, 0, 1);
        rdy_mode = 1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i * 37 - 100);
            end
            begin
                repeat (4) @(posedge clk);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 1;
            end
        join
        rdy_mode = 0;
        drain(20);
        chk("t5_count", got.size(), 10);
        got.delete();

        set_cfg(0, 0, 0, 1);
        rdy_mode = 2;
        drain(2);
        send(55);
        drain(4);
        chk("t6_valid_held", bus.out_valid, 1);
        reset_pulse();
        rdy_mode = 0;
        drain(2);

        set_cfg(0, 0, 0, 4);
        send(100); send(200); send(300); send(400);
        reset_pulse();
        send(1); send(2); send(3); send(4);
        drain(8);
        lit("t6_pool_after_reset", 4);
        lit_none("t6_single");

        chk("model_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
